// File: rtl/mips_pkg.sv
// Shared definitions for the load/store alignment slice.
//   DATA_W            : datapath width of the core and the data memory.
//   SZ_BYTE/HALF/WORD : encodings of the access-size field (2'b11 is reserved).
//   ST_IDLE/ST_RMW_WR : encoding of the lsu_align state register.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RMW_WR = 1'b1;

endpackage

// File: rtl/lsu_align_lane_mux.sv
// lane_mux: purely combinational byte-lane steering for lsu_align.
//   size       : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   uns        : 1 = zero-extend loads, 0 = sign-extend loads
//   ofs        : byte offset within the word (addr[1:0])
//   rd_word    : current memory word
//   wdata      : right-aligned store data from the core
//   load_data  : selected lanes of rd_word, right-aligned and extended
//   store_word : rd_word with the addressed lanes replaced by wdata
// Misaligned combinations produce don't-care values; the caller blocks them.
module lane_mux
    import mips_pkg::*;
(
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [1:0]        ofs,
    input  logic [DATA_W-1:0] rd_word,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_word
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] wdata_rep;
    logic [3:0]        lane_en;

    // Bring the addressed byte/halfword down to bit 0. For aligned halfwords
    // ofs[0] is 0, so shifting by 8*ofs also covers the halfword case.
    assign shifted = rd_word >> {ofs, 3'b000};

    always_comb begin
        case (size)
            SZ_BYTE: load_data = {{24{~uns & shifted[7]}},  shifted[7:0]};
            SZ_HALF: load_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Replicate the store data across the word so every lane already holds
    // the right byte; the lane enables then pick between it and the old data.
    always_comb begin
        case (size)
            SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_en[gi] = (size == SZ_BYTE) ? (ofs == LANE) :
                                 (size == SZ_HALF) ? (ofs[1] == LANE[1]) :
                                                     1'b1;
            assign store_word[8*gi +: 8] = lane_en[gi] ? wdata_rep[8*gi +: 8]
                                                       : rd_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment between the execute stage and a word-wide
// data memory with combinational read and edge-triggered write.
//   clk, rst      : clock; asynchronous active-low reset
//   req, we       : core request valid; 1 = store, 0 = load
//   size, uns     : access size; zero-extend (1) / sign-extend (0) loads
//   addr, wdata   : byte address; right-aligned store data
//   rdata         : right-aligned, extended load result
//   ready, err    : access completes this cycle; access faulted this cycle
//   fault_valid   : sticky fault flag, fault_addr holds the first faulting address
//   mem_we, mem_a, mem_wd, mem_rd : memory port (word index addressing)
// Sub-word stores take two cycles: the first reads and merges, the second
// writes the merged word while the core is held off by ready=0.
module lsu_align
    import mips_pkg::*;
#(
    parameter int DEPTH = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              fault_valid,
    output logic [31:0]       fault_addr,
    output logic              mem_we,
    output logic [31:0]       mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    logic [0:0]        state_reg, state_next;
    logic [DATA_W-1:0] merged_reg, merged_next;
    logic [29:0]       idx_reg, idx_next;
    logic              fault_valid_reg;
    logic [31:0]       fault_addr_reg;

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic              misaligned;
    logic              out_of_range;
    logic              fault;

    lane_mux u_lane_mux (
        .size       (size),
        .uns        (uns),
        .ofs        (addr[1:0]),
        .rd_word    (mem_rd),
        .wdata      (wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr[0];
            SZ_WORD: misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;   // reserved size always faults
        endcase
    end

    assign out_of_range = ({2'b00, addr[31:2]} >= 32'(DEPTH));

    // Faults are only evaluated for a fresh request; in RMW_WR the core
    // inputs are ignored entirely.
    assign fault = req && (state_reg == ST_IDLE) && (misaligned || out_of_range);

    always_comb begin
        state_next  = state_reg;
        merged_next = merged_reg;
        idx_next    = idx_reg;
        mem_we      = 1'b0;
        ready       = 1'b0;
        err         = 1'b0;
        rdata       = '0;
        mem_a       = {2'b00, addr[31:2]};
        mem_wd      = wdata;

        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (fault) begin
                        ready = 1'b1;
                        err   = 1'b1;
                    end else if (!we) begin
                        rdata = load_data;
                        ready = 1'b1;
                    end else if (size == SZ_WORD) begin
                        mem_we = 1'b1;
                        ready  = 1'b1;
                    end else begin
                        merged_next = store_word;
                        idx_next    = addr[31:2];
                        state_next  = ST_RMW_WR;
                    end
                end
            end
            ST_RMW_WR: begin
                mem_a      = {2'b00, idx_reg};
                mem_wd     = merged_reg;
                mem_we     = 1'b1;
                ready      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Reset is asynchronous, so the outputs must go quiet immediately,
        // which also kills a write pending in RMW_WR.
        if (!rst) begin
            mem_we = 1'b0;
            ready  = 1'b0;
            err    = 1'b0;
            rdata  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            merged_reg      <= '0;
            idx_reg         <= '0;
            fault_valid_reg <= 1'b0;
            fault_addr_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            merged_reg <= merged_next;
            idx_reg    <= idx_next;
            // Only the first fault is kept; later ones leave the record alone.
            if (fault && !fault_valid_reg) begin
                fault_valid_reg <= 1'b1;
                fault_addr_reg  <= addr;
            end
        end
    end

    assign fault_valid = fault_valid_reg;
    assign fault_addr  = fault_addr_reg;

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the core's execute stage and the word-wide data memory. It turns byte-addressed loads and stores of byte, halfword or word size into word-indexed memory accesses. Loads are extracted and sign- or zero-extended. Sub-word stores use a two-cycle read-modify-write and stall the core for one cycle. Misaligned and out-of-range accesses are blocked and recorded.

## Interface
Parameters:
- DEPTH, 100, number of 32-bit words in the attached data memory.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  core access request, valid this cycle.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: SZ_BYTE, SZ_HALF or SZ_WORD; the value 2'b11 is reserved and faults.
- uns  in  1  load zero-extend (1) or sign-extend (0).
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, right-aligned and extended.
- ready  out  1  access completes this cycle; the core stalls while req=1 and ready=0.
- err  out  1  access faulted this cycle (one-cycle pulse with ready).
- fault_valid  out  1  sticky fault flag.
- fault_addr  out  32  byte address of the first fault.
- mem_we  out  1  memory write enable.
- mem_a  out  32  word index to memory (addr>>2).
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_a.

## Operation
- Byte lanes are little-endian: byte k of a word occupies bits 8k+7:8k. Halfword h (addr[1]) occupies bits 16h+15:16h.
- Fault conditions, checked in IDLE:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - size=2'b11;
  - addr[31:2] ≥ DEPTH.
- A faulting access never asserts mem_we. It returns ready=1, err=1 and rdata=0. The first fault sets fault_valid and captures fault_addr; later faults do not overwrite them.
- State machine with two states, IDLE and RMW_WR:
  - IDLE, no req: mem_we=0, ready=0.
  - IDLE, load: mem_a=addr>>2, rdata is extracted from mem_rd, ready=1.
  - IDLE, word store: mem_we=1, mem_wd=wdata, ready=1.
  - IDLE, byte or half store: ready=0. On the edge, merge the selected lanes of wdata into mem_rd and register the result, register the word index, then go to RMW_WR.
  - RMW_WR: mem_a=saved index, mem_wd=merged word, mem_we=1, ready=1, then return to IDLE. Core inputs are ignored in this state; the saved values are used even if req drops.
- The sticky fault flag is cleared only by reset.

## Timing
- Loads, word stores and faults complete in 1 cycle (ready in the same cycle as req).
- Sub-word stores complete in 2 cycles (ready=0, then ready=1). The memory is written at the end of the second cycle.
- A load issued in the cycle after an RMW sees the updated word, because memory writes on the edge.
- Reset values: state=IDLE, merged word=0, saved index=0, fault_valid=0, fault_addr=0.
- While rst=0, mem_we=0, ready=0, err=0 and rdata=0, independent of the other inputs.
- Reset asserted in RMW_WR aborts the pending write: no mem_we, memory unchanged, state returns to IDLE.
- Back-to-back sub-word stores complete at a rate of one per 2 cycles. Requests issued while in RMW_WR are not accepted until IDLE.

## Structure
- mips_pkg holds:
  - SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state encoding (IDLE, RMW_WR);
  - DATA_W=32.
- Sub-module lane_mux (combinational) provides load extraction and sign/zero extension, plus store merge by size and addr[1:0]. lsu_align instantiates it and holds the FSM, the RMW registers and the fault logic.

## Test plan
- Reset, then word store 0xDEADBEEF to addr 0x8. Required: mem_we=1, mem_a=2, ready=1 in the same cycle. A following word load from 0x8 returns rdata=0xDEADBEEF.
- Byte store 0xAB to addr 0x9 over word 0xDEADBEEF. Required: cycle 1 ready=0, mem_we=0; cycle 2 mem_we=1, mem_wd=0xDEADABEF. Signed byte load from 0x9 then returns 0xFFFFFFAB; unsigned returns 0x000000AB.
- Half store 0x1234 to addr 0xA over word 0xDEADABEF. Required: mem_wd=0x1234ABEF. Signed half load from 0xA returns 0x00001234; signed half load from 0x8 returns 0xFFFFABEF.
- Half load from addr 0x5. Required: ready=1, err=1, mem_we=0, fault_valid=1, fault_addr=0x5. A following word store to 0x193 still reports err but fault_addr stays 0x5.
- Word store to addr 0x190 (index 100, DEPTH=100). Required: err=1 and no mem_we.
- Byte store, with rst pulled low during RMW_WR. Required: mem_we never asserts, the memory word is unchanged, and after rst returns high the state is IDLE, fault_valid=0 and ready=0.
